user_ddr_arbiter: RTL



---
 rtl/user_ddr_arbiter_pkg.sv | 24 ++
 rtl/user_ddr_arbiter_rr.sv | 45 ++++
 rtl/user_ddr_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/user_ddr_arbiter_pkg.sv
// Purpose : shared constants for the user DDR port arbiter.
//   - DDR user interface widths (address, data, byte enable)
//   - FSM state encoding used by user_ddr_arbiter
//   - helper for sizing requester index / pointer registers
package user_ddr_arbiter_pkg;

    localparam int unsigned DDR_ADDR_W = 27;
    localparam int unsigned DDR_DATA_W = 256;
    localparam int unsigned DDR_BE_W   = DDR_DATA_W / 8;

    localparam int unsigned ST_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WR     = 3'd1;
    localparam logic [2:0] ST_RD     = 3'd2;
    localparam logic [2:0] ST_RDDATA = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Bits needed to hold a requester index 0..n-1 (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_ddr_arbiter_rr.sv
// Purpose : combinational round-robin pick for the user DDR arbiter.
//   Searches i_req starting at i_ptr, wrapping modulo NUM_REQ, and returns
//   the first set requester as a one-hot grant plus its index.
// Ports   :
//   i_req      requester request vector
//   i_ptr      highest-priority requester index
//   o_grant_c  one-hot pick (0 when no request)
//   o_idx_c    index of the pick
//   o_valid_c  any requester picked
module ddr_rr_arbiter
    import user_ddr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [PTR_W-1:0]   o_idx_c,
    output logic               o_valid_c
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        w_idx     = 0;
        for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
            w_idx = int'(i_ptr) + off;
            if (w_idx >= int'(NUM_REQ)) begin
                w_idx = w_idx - int'(NUM_REQ);
            end
            if (i_req[w_idx]) begin
                o_grant_c        = '0;
                o_grant_c[w_idx] = 1'b1;
                o_idx_c          = PTR_W'(w_idx);
                o_valid_c        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/user_ddr_arbiter.sv
// Purpose : round-robin arbiter/sequencer sharing the single user DDR port
//   between NUM_REQ requesters, one transaction (write, or read plus its
//   returned data) at a time.
// Optional: define DDR_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog;
//   without it the FSM waits indefinitely and o_timeout stays 0.
// Ports   :
//   i_ddr_clk, i_rst                     clock, synchronous active-high reset
//   i_req / i_req_wr / i_req_addr /
//   i_req_data / i_req_be_n              packed per-requester requests
//   o_req_ack, o_rd_data, o_rd_data_valid  per-requester completion / read return
//   o_grant, o_timeout                   current owner, watchdog abort pulse
//   o_ddr_* / i_ddr_*                    switch DDR user interface
module user_ddr_arbiter
    import user_ddr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = DDR_ADDR_W,
    parameter int unsigned DATA_W         = DDR_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_ddr_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     i_req_data,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] i_req_be_n,
    output logic [NUM_REQ-1:0]            o_req_ack,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic [NUM_REQ-1:0]            o_rd_data_valid,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_timeout,
    output logic [ADDR_W-1:0]             o_ddr_addr,
    output logic [DATA_W-1:0]             o_ddr_wr_data,
    output logic [DATA_W/8-1:0]           o_ddr_wr_data_be_n,
    output logic                          o_ddr_wr_data_valid,
    output logic                          o_ddr_rd,
    input  logic                          i_ddr_wr_ack,
    input  logic                          i_ddr_rd_ack,
    input  logic [DATA_W-1:0]             i_ddr_rd_data,
    input  logic                          i_ddr_rd_data_valid
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = idx_width(NUM_REQ);

    // Registered state and outputs
    logic [ST_W-1:0]    r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [ADDR_W-1:0]  r_ddr_addr;
    logic [DATA_W-1:0]  r_ddr_wr_data;
    logic [BE_W-1:0]    r_ddr_be_n;
    logic               r_ddr_wr_valid;
    logic               r_ddr_rd;
    logic [NUM_REQ-1:0] r_req_ack;
    logic [DATA_W-1:0]  r_rd_data;
    logic [NUM_REQ-1:0] r_rd_data_valid;
    logic               r_timeout;

    // Next-state values
    logic [ST_W-1:0]    w_state_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [ADDR_W-1:0]  w_ddr_addr_nxt;
    logic [DATA_W-1:0]  w_ddr_wr_data_nxt;
    logic [BE_W-1:0]    w_ddr_be_n_nxt;
    logic               w_ddr_wr_valid_nxt;
    logic               w_ddr_rd_nxt;
    logic [NUM_REQ-1:0] w_req_ack_nxt;
    logic [DATA_W-1:0]  w_rd_data_nxt;
    logic [NUM_REQ-1:0] w_rd_data_valid_nxt;
    logic               w_timeout_nxt;

    // Arbiter pick
    logic [NUM_REQ-1:0] w_arb_grant;
    logic [PTR_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic               w_tmr_expired;

    ddr_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_grant_c (w_arb_grant),
        .o_idx_c   (w_arb_idx),
        .o_valid_c (w_arb_valid)
    );

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMR_W-1:0] r_tmr;

    // Watchdog: cleared on every state change, counts while waiting on the DDR.
    always_ff @(posedge i_ddr_clk) begin
        if (i_rst || (r_state != w_state_nxt)) begin
            r_tmr <= '0;
        end else if ((r_state == ST_WR) || (r_state == ST_RD) || (r_state == ST_RDDATA)) begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end

    assign w_tmr_expired = (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmr_expired = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt         = r_state;
        w_ptr_nxt           = r_ptr;
        w_owner_nxt         = r_owner;
        w_grant_nxt         = r_grant;
        w_ddr_addr_nxt      = r_ddr_addr;
        w_ddr_wr_data_nxt   = r_ddr_wr_data;
        w_ddr_be_n_nxt      = r_ddr_be_n;
        w_ddr_wr_valid_nxt  = r_ddr_wr_valid;
        w_ddr_rd_nxt        = r_ddr_rd;
        w_rd_data_nxt       = r_rd_data;
        w_req_ack_nxt       = '0;
        w_rd_data_valid_nxt = '0;
        w_timeout_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_grant_nxt       = w_arb_grant;
                    w_owner_nxt       = w_arb_idx;
                    w_ddr_addr_nxt    = i_req_addr[w_arb_idx*ADDR_W +: ADDR_W];
                    w_ddr_wr_data_nxt = i_req_data[w_arb_idx*DATA_W +: DATA_W];
                    w_ddr_be_n_nxt    = i_req_be_n[w_arb_idx*BE_W +: BE_W];
                    if (i_req_wr[w_arb_idx]) begin
                        w_ddr_wr_valid_nxt = 1'b1;
                        w_state_nxt        = ST_WR;
                    end else begin
                        w_ddr_rd_nxt = 1'b1;
                        w_state_nxt  = ST_RD;
                    end
                end
            end

            ST_WR: begin
                if (i_ddr_wr_ack || w_tmr_expired) begin
                    w_ddr_wr_valid_nxt = 1'b0;
                    w_req_ack_nxt      = r_grant;
                    w_timeout_nxt      = !i_ddr_wr_ack;
                    w_grant_nxt        = '0;
                    w_state_nxt        = ST_DONE;
                end
            end

            ST_RD: begin
                if (i_ddr_rd_ack) begin
                    w_ddr_rd_nxt = 1'b0;
                    // Data returned alongside the ack completes the read here.
                    if (i_ddr_rd_data_valid) begin
                        w_rd_data_nxt       = i_ddr_rd_data;
                        w_rd_data_valid_nxt = r_grant;
                        w_req_ack_nxt       = r_grant;
                        w_grant_nxt         = '0;
                        w_state_nxt         = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RDDATA;
                    end
                end else if (w_tmr_expired) begin
                    w_ddr_rd_nxt  = 1'b0;
                    w_req_ack_nxt = r_grant;
                    w_timeout_nxt = 1'b1;
                    w_grant_nxt   = '0;
                    w_state_nxt   = ST_DONE;
                end
            end

            ST_RDDATA: begin
                if (i_ddr_rd_data_valid) begin
                    w_rd_data_nxt       = i_ddr_rd_data;
                    w_rd_data_valid_nxt = r_grant;
                    w_req_ack_nxt       = r_grant;
                    w_grant_nxt         = '0;
                    w_state_nxt         = ST_DONE;
                end else if (w_tmr_expired) begin
                    w_req_ack_nxt = r_grant;
                    w_timeout_nxt = 1'b1;
                    w_grant_nxt   = '0;
                    w_state_nxt   = ST_DONE;
                end
            end

            ST_DONE: begin
                // Gap cycle: the acked requester drops i_req before re-arbitration.
                if (r_owner == PTR_W'(NUM_REQ - 1)) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_owner + PTR_W'(1);
                end
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_ddr_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_owner         <= '0;
            r_grant         <= '0;
            r_ddr_addr      <= '0;
            r_ddr_wr_data   <= '0;
            r_ddr_be_n      <= '0;
            r_ddr_wr_valid  <= 1'b0;
            r_ddr_rd        <= 1'b0;
            r_req_ack       <= '0;
            r_rd_data       <= '0;
            r_rd_data_valid <= '0;
            r_timeout       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ptr           <= w_ptr_nxt;
            r_owner         <= w_owner_nxt;
            r_grant         <= w_grant_nxt;
            r_ddr_addr      <= w_ddr_addr_nxt;
            r_ddr_wr_data   <= w_ddr_wr_data_nxt;
            r_ddr_be_n      <= w_ddr_be_n_nxt;
            r_ddr_wr_valid  <= w_ddr_wr_valid_nxt;
            r_ddr_rd        <= w_ddr_rd_nxt;
            r_req_ack       <= w_req_ack_nxt;
            r_rd_data       <= w_rd_data_nxt;
            r_rd_data_valid <= w_rd_data_valid_nxt;
            r_timeout       <= w_timeout_nxt;
        end
    end

    assign o_req_ack           = r_req_ack;
    assign o_rd_data           = r_rd_data;
    assign o_rd_data_valid     = r_rd_data_valid;
    assign o_grant             = r_grant;
    assign o_ddr_addr          = r_ddr_addr;
    assign o_ddr_wr_data       = r_ddr_wr_data;
    assign o_ddr_wr_data_be_n  = r_ddr_be_n;
    assign o_ddr_wr_data_valid = r_ddr_wr_valid;
    assign o_ddr_rd            = r_ddr_rd;
`ifdef DDR_ARB_TIMEOUT_EN
    assign o_timeout           = r_timeout;
`else
    assign o_timeout           = 1'b0;
`endif

endmodule
